ofm_writeback: RTL
==================

# ofm_writeback

Output write-back stage that sits directly downstream of the second max-pool stage and upstream of the OFM dual-port RAM. It accepts one beat per pooled output pixel, carrying SYSTOLIC_SIZE filter results side by side. It buffers up to two beats, serialises each beat into one 16-bit RAM write per valid filter lane, and generates the planar OFM address. It raises `done` once every pooled pixel of every filter group has been written.

## Interface
- SYSTOLIC_SIZE, 16, lanes per input beat (filters computed in parallel)
- DATA_WIDTH, 8, operand width; pooled values are 2*DATA_WIDTH bits
- OFM_POOL_SIZE, 208, pooled OFM height = width
- NO_FILTER, 16, total filters (output channels)
- ADDR_WIDTH, 20, OFM RAM address width; must satisfy NO_FILTER*OFM_POOL_SIZE^2 <= 2^ADDR_WIDTH

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a layer (honoured in any state)
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  SYSTOLIC_SIZE*2*DATA_WIDTH  lane k = bits [16k+15:16k] = filter (filter_base+k)
- ofm_we  out  1  RAM write enable
- ofm_addr  out  ADDR_WIDTH  RAM word address
- ofm_data  out  2*DATA_WIDTH  RAM write data
- done  out  1  layer complete; level, held until next start

## Operation
- States: IDLE, RUN, DONE. Reset -> IDLE. start -> RUN from any state. Entering RUN clears the buffer, lane counter, pixel counter and filter_base, and deasserts done.
- Beat order: raster within a group (col fastest, then row), OFM_POOL_SIZE^2 beats per group; groups in order filter_base = 0, SYSTOLIC_SIZE, 2*SYSTOLIC_SIZE, ...; G = ceil(NO_FILTER/SYSTOLIC_SIZE) groups.
- Handshake: transfer when in_valid & in_ready. in_ready = (state==RUN) & (buffer count < 2), computed from registered count only; no same-cycle pass-through when full.
- Buffer: 2-entry FIFO of whole beats. A beat is pushed on transfer and popped after its last lane is written.
- Serialiser: drains the head beat lane 0..L-1, one write per cycle, where L = min(SYSTOLIC_SIZE, NO_FILTER - filter_base). Lanes >= L are discarded without a write.
- Address: ofm_addr = (filter_base+lane)*OFM_POOL_SIZE^2 + row*OFM_POOL_SIZE + col. Generated incrementally; no multipliers on the write path. The result must be exact for all legal parameter values.
- Pixel counter advances on each pop. It wraps at OFM_POOL_SIZE^2, then filter_base += SYSTOLIC_SIZE.
- Completion: pop of the last pixel of group G-1 -> DONE. In DONE and IDLE, in_ready=0 and ofm_we=0.
- Data is passed through unmodified; no saturation or sign handling.
- start during RUN: buffered beats are dropped, any write in flight for the current cycle completes, and the layer restarts from zero.

## Timing
- Reset values: in_ready=0, ofm_we=0, ofm_addr=0, ofm_data=0, done=0.
- ofm_we, ofm_addr and ofm_data are registered. A beat accepted at edge t into an empty buffer produces its first write at edge t+1 and its last at t+L.
- Sustained throughput is one beat per L cycles.
- With a full buffer and a pop in cycle c, in_ready rises in cycle c+1.
- done rises on the edge after the final write, so it is visible the cycle after the last ofm_we. It stays high until start.
- ofm_we is never asserted in two different states within the same cycle. Back-to-back lanes of consecutive beats are contiguous, with no bubble.

## Test plan
- Reset, then idle with in_valid=1 -> in_ready=0, ofm_we=0, done=0; outputs remain 0.
- Bench params OFM_POOL_SIZE=4, NO_FILTER=20, SYSTOLIC_SIZE=16; start, one beat with lane k = 0x0100+k -> 16 writes on consecutive cycles t+1..t+16, addr = 16k, data 0x0100+k.
- in_valid held high for 16 beats -> in_ready pattern allows at most 2 buffered beats. All 256 writes occur with no gaps and no loss. Addresses cover every {k*16+p}, k<16, p<16, exactly once.
- Second group, beat at pixel (1,2) (p=6) -> exactly 4 writes, addr 262, 278, 294, 310, from lanes 0..3. Lanes 4..15 are not written, and the beat occupies 4 cycles.
- After all 32 beats -> done=1 the cycle after the write to addr 319; in_ready=0. A following start -> done=0 the next cycle and in_ready=1.
- Assert start after 5 beats with 2 buffered -> buffered beats produce no further writes. The next beat writes addr 0..15 again.

Source files
------------

// File: rtl/ofm_writeback.sv
// ofm_writeback: write-back stage between the last max-pool stage and the OFM RAM.
// Accepts one beat per pooled pixel (SYSTOLIC_SIZE filter lanes side by side),
// buffers up to two beats, serialises each beat into one RAM write per valid
// filter lane and generates the planar OFM address incrementally.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start               one-cycle pulse, (re)starts a layer from any state
//   in_valid/in_ready   input beat handshake; in_data lane k = filter_base + k
//   ofm_we/addr/data    registered RAM write port
//   done                layer complete, held until the next start
module ofm_writeback #(
    parameter int unsigned SYSTOLIC_SIZE = 16,
    parameter int unsigned DATA_WIDTH    = 8,
    parameter int unsigned OFM_POOL_SIZE = 208,
    parameter int unsigned NO_FILTER     = 16,
    parameter int unsigned ADDR_WIDTH    = 20
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    start,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [SYSTOLIC_SIZE*2*DATA_WIDTH-1:0]   in_data,
    output logic                                    ofm_we,
    output logic [ADDR_WIDTH-1:0]                   ofm_addr,
    output logic [2*DATA_WIDTH-1:0]                 ofm_data,
    output logic                                    done
);

    localparam int unsigned LW       = 2 * DATA_WIDTH;
    localparam int unsigned BW       = SYSTOLIC_SIZE * LW;
    localparam int unsigned P2       = OFM_POOL_SIZE * OFM_POOL_SIZE;
    localparam int unsigned GRP_STEP = SYSTOLIC_SIZE * P2;
    // Internal address is wide enough to hold the base of the group past the last one.
    localparam int unsigned IAW      = $clog2((NO_FILTER + SYSTOLIC_SIZE) * P2 + 1);
    localparam int unsigned PW       = $clog2(P2 + 1);
    localparam int unsigned CW       = $clog2(SYSTOLIC_SIZE + 1);
    localparam int unsigned RW       = $clog2(NO_FILTER + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_d;
    logic [BW-1:0]    buf_q [2];
    logic             wr_ptr, wr_ptr_d;
    logic             rd_ptr, rd_ptr_d;
    logic [1:0]       count, count_d;
    logic [CW-1:0]    lane_cnt, lane_cnt_d;
    logic [CW-1:0]    lane_lim, lane_lim_d;
    logic [PW-1:0]    pix_cnt, pix_cnt_d;
    logic [RW-1:0]    rem, rem_d;           // NO_FILTER - filter_base
    logic [IAW-1:0]   grp_base, grp_base_d; // filter_base * P2
    logic [IAW-1:0]   pix_addr, pix_addr_d; // address of lane 0 of the head pixel
    logic [IAW-1:0]   lane_addr, lane_addr_d;
    logic             in_ready_d, ofm_we_d, done_d;
    logic [ADDR_WIDTH-1:0] ofm_addr_d;
    logic [LW-1:0]    ofm_data_d;
    logic             push, pop;
    logic [BW-1:0]    head;
    logic [LW-1:0]    lane_word;

    // Number of lanes carrying real filters for a group with r filters remaining.
    function automatic logic [CW-1:0] lane_limit(input logic [RW-1:0] r);
        if (32'(r) >= SYSTOLIC_SIZE) begin
            return CW'(SYSTOLIC_SIZE);
        end
        return CW'(r);
    endfunction

    // Next-state, buffer, serialiser and address generation.
    always_comb begin
        state_d     = state;
        wr_ptr_d    = wr_ptr;
        rd_ptr_d    = rd_ptr;
        count_d     = count;
        lane_cnt_d  = lane_cnt;
        lane_lim_d  = lane_lim;
        pix_cnt_d   = pix_cnt;
        rem_d       = rem;
        grp_base_d  = grp_base;
        pix_addr_d  = pix_addr;
        lane_addr_d = lane_addr;
        ofm_we_d    = 1'b0;
        ofm_addr_d  = ofm_addr;
        ofm_data_d  = ofm_data;
        pop         = 1'b0;
        push        = in_valid && in_ready && (state == RUN) && !start;
        head        = buf_q[rd_ptr];
        lane_word   = LW'(head >> (32'(lane_cnt) * LW));

        case (state)
            RUN: begin
                if (count != 2'd0) begin
                    ofm_we_d   = 1'b1;
                    ofm_addr_d = ADDR_WIDTH'(lane_addr);
                    ofm_data_d = lane_word;
                    if (lane_cnt == lane_lim - CW'(1)) begin
                        pop        = 1'b1;
                        lane_cnt_d = '0;
                        if (pix_cnt == PW'(P2 - 1)) begin
                            pix_cnt_d   = '0;
                            grp_base_d  = grp_base + IAW'(GRP_STEP);
                            pix_addr_d  = grp_base + IAW'(GRP_STEP);
                            lane_addr_d = grp_base + IAW'(GRP_STEP);
                            if (32'(rem) <= SYSTOLIC_SIZE) begin
                                state_d = DONE;
                            end else begin
                                rem_d      = rem - RW'(SYSTOLIC_SIZE);
                                lane_lim_d = lane_limit(rem - RW'(SYSTOLIC_SIZE));
                            end
                        end else begin
                            pix_cnt_d   = pix_cnt + PW'(1);
                            pix_addr_d  = pix_addr + IAW'(1);
                            lane_addr_d = pix_addr + IAW'(1);
                        end
                    end else begin
                        lane_cnt_d  = lane_cnt + CW'(1);
                        lane_addr_d = lane_addr + IAW'(P2);
                    end
                end
            end
            default: ;
        endcase

        if (push) begin
            wr_ptr_d = ~wr_ptr;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr;
        end
        count_d = count + 2'(push) - 2'(pop);

        // Start wins over everything; the write computed this cycle still issues.
        if (start) begin
            state_d     = RUN;
            wr_ptr_d    = 1'b0;
            rd_ptr_d    = 1'b0;
            count_d     = '0;
            lane_cnt_d  = '0;
            pix_cnt_d   = '0;
            rem_d       = RW'(NO_FILTER);
            lane_lim_d  = lane_limit(RW'(NO_FILTER));
            grp_base_d  = '0;
            pix_addr_d  = '0;
            lane_addr_d = '0;
        end

        in_ready_d = (state_d == RUN) && (count_d < 2'd2);
        // One cycle behind the state so done follows the final write.
        done_d     = (state == DONE) && !start;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= '0;
            lane_cnt  <= '0;
            lane_lim  <= '0;
            pix_cnt   <= '0;
            rem       <= '0;
            grp_base  <= '0;
            pix_addr  <= '0;
            lane_addr <= '0;
            in_ready  <= 1'b0;
            ofm_we    <= 1'b0;
            ofm_addr  <= '0;
            ofm_data  <= '0;
            done      <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
        end else begin
            state     <= state_d;
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            count     <= count_d;
            lane_cnt  <= lane_cnt_d;
            lane_lim  <= lane_lim_d;
            pix_cnt   <= pix_cnt_d;
            rem       <= rem_d;
            grp_base  <= grp_base_d;
            pix_addr  <= pix_addr_d;
            lane_addr <= lane_addr_d;
            in_ready  <= in_ready_d;
            ofm_we    <= ofm_we_d;
            ofm_addr  <= ofm_addr_d;
            ofm_data  <= ofm_data_d;
            done      <= done_d;
            if (push) begin
                buf_q[wr_ptr] <= in_data;
            end
        end
    end

endmodule
